// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_cfg
// Purpose  : Parametrised UART receiver. It synchronises the input line and
//            takes a 2-of-3 majority vote at mid-bit. It detects parity,
//            framing and break conditions, and delivers one word per frame
//            with a single-cycle valid pulse.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_serial_i,
    output logic                 rx_dv_o,
    output logic [DATA_BITS-1:0] rx_byte_o,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 break_o,
    output logic                 busy_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int c_IDX_W = $clog2(DATA_BITS);

    // Three vote samples sit around the mid-bit count H; the vote is decided
    // on the third one so the decision can use the live line value.
    localparam logic [c_CNT_W-1:0] c_H       = c_CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [c_CNT_W-1:0] c_H_M1    = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_H_P1    = c_CNT_W'(CLKS_PER_BIT / 2 + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_BITS - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

    localparam logic c_PAR_EN        = (PARITY_EN != 0);
    localparam logic c_PAR_ODD       = (PARITY_ODD != 0);
    localparam logic c_STOP_LAST_IDX = (STOP_BITS == 2);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_START     = 3'd1;
    localparam logic [2:0] c_ST_DATA      = 3'd2;
    localparam logic [2:0] c_ST_PARITY    = 3'd3;
    localparam logic [2:0] c_ST_STOP      = 3'd4;
    localparam logic [2:0] c_ST_WAIT_HIGH = 3'd5;

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rxs;

    logic [2:0]             r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_CNT_W-1:0]     w_cnt_next;
    logic [c_IDX_W-1:0]     r_idx;
    logic                   r_stop_idx;
    logic                   r_stop_bad;
    logic                   r_s_a;
    logic                   r_s_b;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par_vote;
    logic                   r_par_bad;

    logic                   r_dv;
    logic [DATA_BITS-1:0]   r_byte;
    logic                   r_perr;
    logic                   r_ferr;
    logic                   r_brk;

    logic                   w_vote;
    logic                   w_decide;
    logic                   w_last_stop;
    logic                   w_ferr_now;
    logic                   w_data_zero;

    // ------------------------------------------------------------------------
    // Input synchroniser. The flops reset high so that reset release is not
    // seen as a start bit.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx_serial_i};
        end
    end

    assign w_rxs = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    // The 2-of-3 majority uses the two stored samples and the live third sample.
    assign w_vote      = (r_s_a & r_s_b) | (r_s_a & w_rxs) | (r_s_b & w_rxs);
    assign w_decide    = (r_cnt == c_H_P1);
    assign w_cnt_next  = (r_cnt == c_CNT_MAX) ? '0 : (r_cnt + c_CNT_ONE);
    assign w_last_stop = (r_stop_idx == c_STOP_LAST_IDX);
    // Framing error covers the stop bit now being decided and any earlier stop bit.
    assign w_ferr_now  = r_stop_bad | ~w_vote;
    assign w_data_zero = (r_shift == '0);

    // ------------------------------------------------------------------------
    // Receive FSM. It holds the bit counter, the vote samples, the data shift
    // register and the registered outputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_stop_idx <= 1'b0;
            r_stop_bad <= 1'b0;
            r_s_a      <= 1'b1;
            r_s_b      <= 1'b1;
            r_shift    <= '0;
            r_par_vote <= 1'b0;
            r_par_bad  <= 1'b0;
            r_dv       <= 1'b0;
            r_byte     <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_brk      <= 1'b0;
        end else begin
            r_dv <= 1'b0;

            // The first two vote samples are taken at H-1 and H.
            if (r_cnt == c_H_M1) begin
                r_s_a <= w_rxs;
            end
            if (r_cnt == c_H) begin
                r_s_b <= w_rxs;
            end

            case (r_state)
                c_ST_IDLE: begin
                    r_idx      <= '0;
                    r_stop_idx <= 1'b0;
                    r_stop_bad <= 1'b0;
                    if (!w_rxs) begin
                        // The cycle in which the low level is seen counts as
                        // count 0, so the next count is 1.
                        r_state <= c_ST_START;
                        r_cnt   <= c_CNT_ONE;
                    end else begin
                        r_cnt <= '0;
                    end
                end

                c_ST_START: begin
                    r_cnt <= w_cnt_next;
                    if (w_decide) begin
                        if (w_vote) begin
                            // False start: return quietly and leave the outputs unchanged.
                            r_state <= c_ST_IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_state    <= c_ST_DATA;
                            r_par_vote <= 1'b0;
                            r_par_bad  <= 1'b0;
                        end
                    end
                end

                c_ST_DATA: begin
                    r_cnt <= w_cnt_next;
                    if (w_decide) begin
                        // The word arrives LSB first. After DATA_BITS right
                        // shifts, the first bit received sits in bit 0.
                        r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                        if (r_idx == c_IDX_LAST) begin
                            r_idx   <= '0;
                            r_state <= c_PAR_EN ? c_ST_PARITY : c_ST_STOP;
                        end else begin
                            r_idx <= r_idx + c_IDX_ONE;
                        end
                    end
                end

                c_ST_PARITY: begin
                    r_cnt <= w_cnt_next;
                    if (w_decide) begin
                        r_par_vote <= w_vote;
                        r_par_bad  <= ((^r_shift) ^ w_vote) != c_PAR_ODD;
                        r_state    <= c_ST_STOP;
                    end
                end

                c_ST_STOP: begin
                    r_cnt <= w_cnt_next;
                    if (w_decide) begin
                        if (w_last_stop) begin
                            r_dv    <= 1'b1;
                            r_byte  <= r_shift;
                            r_ferr  <= w_ferr_now;
                            r_perr  <= c_PAR_EN & r_par_bad;
                            r_brk   <= w_ferr_now & w_data_zero &
                                       (~c_PAR_EN | ~r_par_vote);
                            r_cnt   <= '0;
                            // A low stop bit may be a break or a stuck line.
                            // Wait for a high level before arming again.
                            r_state <= w_ferr_now ? c_ST_WAIT_HIGH : c_ST_IDLE;
                        end else begin
                            r_stop_idx <= 1'b1;
                            r_stop_bad <= ~w_vote;
                        end
                    end
                end

                c_ST_WAIT_HIGH: begin
                    r_cnt <= '0;
                    if (w_rxs) begin
                        r_state <= c_ST_IDLE;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rx_dv_o      = r_dv;
    assign rx_byte_o    = r_byte;
    assign parity_err_o = r_perr;
    assign frame_err_o  = r_ferr;
    assign break_o      = r_brk;
    assign busy_o       = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_cfg
// Purpose  : Scoreboard bench for uart_rx_cfg. It drives three receivers
//            (8N1, 7E1 and 8N2 at 16 clocks per bit) with directed frames.
//            A monitor process checks every rx_dv_o pulse against the
//            queued expectation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cfg;

    localparam int c_CPB  = 16;
    localparam int c_H    = c_CPB / 2;
    localparam int c_SYNC = 2;

    typedef struct {
        int         inst;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
        int         cyc;
    } exp_t;

    logic       r_clk = 1'b0;
    logic       r_rst_n = 1'b0;
    logic [2:0] r_line = 3'b111;

    logic [2:0] w_dv;
    logic [2:0] w_perr;
    logic [2:0] w_ferr;
    logic [2:0] w_brk;
    logic [2:0] w_busy;
    logic [8:0] w_byte [3];

    exp_t q_exp[$];
    exp_t mon_e;
    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;

    always #5 r_clk = ~r_clk;

    // Free-running cycle count, used to check the pulse latency.
    always @(posedge r_clk) cyc <= cyc + 1;

    uart_rx_cfg #(.CLKS_PER_BIT(c_CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                  .STOP_BITS(1), .SYNC_STAGES(c_SYNC)) u_a (
        .clk_i(r_clk), .rst_ni(r_rst_n), .rx_serial_i(r_line[0]),
        .rx_dv_o(w_dv[0]), .rx_byte_o(w_byte[0][7:0]), .parity_err_o(w_perr[0]),
        .frame_err_o(w_ferr[0]), .break_o(w_brk[0]), .busy_o(w_busy[0]));

    uart_rx_cfg #(.CLKS_PER_BIT(c_CPB), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0),
                  .STOP_BITS(1), .SYNC_STAGES(c_SYNC)) u_b (
        .clk_i(r_clk), .rst_ni(r_rst_n), .rx_serial_i(r_line[1]),
        .rx_dv_o(w_dv[1]), .rx_byte_o(w_byte[1][6:0]), .parity_err_o(w_perr[1]),
        .frame_err_o(w_ferr[1]), .break_o(w_brk[1]), .busy_o(w_busy[1]));

    uart_rx_cfg #(.CLKS_PER_BIT(c_CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                  .STOP_BITS(2), .SYNC_STAGES(c_SYNC)) u_c (
        .clk_i(r_clk), .rst_ni(r_rst_n), .rx_serial_i(r_line[2]),
        .rx_dv_o(w_dv[2]), .rx_byte_o(w_byte[2][7:0]), .parity_err_o(w_perr[2]),
        .frame_err_o(w_ferr[2]), .break_o(w_brk[2]), .busy_o(w_busy[2]));

    assign w_byte[0][8]   = 1'b0;
    assign w_byte[1][8:7] = 2'b00;
    assign w_byte[2][8]   = 1'b0;

    function automatic int n_data(input int w);
        return (w == 1) ? 7 : 8;
    endfunction

    function automatic int n_par(input int w);
        return (w == 1) ? 1 : 0;
    endfunction

    function automatic int n_stop(input int w);
        return (w == 2) ? 2 : 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Wait n clock edges and leave the bench 1 time unit after the last edge.
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge r_clk);
        #1;
    endtask

    task automatic drive_bit(input int w, input logic b);
        r_line[w] = b;
        wait_cyc(c_CPB);
    endtask

    // Holds bit b for one bit time, inverted for the single cycle at offset off.
    task automatic drive_bit_glitch(input int w, input logic b, input int off);
        r_line[w] = b;
        wait_cyc(off);
        r_line[w] = ~b;
        wait_cyc(1);
        r_line[w] = b;
        wait_cyc(c_CPB - off - 1);
    endtask

    // Sends one frame and queues its expected result. T0 falls SYNC_STAGES+1
    // edges after the edge that precedes the start bit. The pulse is then
    // visible after edge T0 + H + 1 + N*CPB.
    task automatic send_frame(input int w, input logic [8:0] d, input logic pbit,
                              input logic s2, input logic ep, input logic ef,
                              input logic eb, input int gbit);
        exp_t e;
        int   n;
        n      = n_data(w) + n_par(w) + n_stop(w);
        e.inst = w;
        e.data = d;
        e.perr = ep;
        e.ferr = ef;
        e.brk  = eb;
        e.cyc  = cyc + c_SYNC + 1 + c_H + 1 + n * c_CPB;
        q_exp.push_back(e);
        drive_bit(w, 1'b0);
        for (int i = 0; i < n_data(w); i++) begin
            if (i == gbit) drive_bit_glitch(w, d[i], c_H);
            else           drive_bit(w, d[i]);
        end
        if (n_par(w) == 1) drive_bit(w, pbit);
        drive_bit(w, 1'b1);
        if (n_stop(w) == 2) drive_bit(w, s2);
    endtask

    // Monitor: each pulse pops one expectation and is checked against it.
    always @(negedge r_clk) begin
        if (w_dv != 3'b000) begin
            if (q_exp.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL unexpected_pulse actual dv=%b required none (t=%0t)", w_dv, $time);
            end else begin
                mon_e = q_exp.pop_front();
                chk("pulse_inst",  {29'd0, w_dv}, 32'(3'b001 << mon_e.inst));
                chk("rx_byte",     {23'd0, w_byte[mon_e.inst]}, {23'd0, mon_e.data});
                chk("parity_err",  {31'd0, w_perr[mon_e.inst]}, {31'd0, mon_e.perr});
                chk("frame_err",   {31'd0, w_ferr[mon_e.inst]}, {31'd0, mon_e.ferr});
                chk("break",       {31'd0, w_brk[mon_e.inst]},  {31'd0, mon_e.brk});
                chk("pulse_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state.
        wait_cyc(5);
        chk("reset_dv",   {29'd0, w_dv},   0);
        chk("reset_busy", {29'd0, w_busy}, 0);
        chk("reset_byte_a", {23'd0, w_byte[0]}, 0);
        r_rst_n = 1'b1;
        wait_cyc(3);
        chk("post_reset_flags", {23'd0, w_perr, w_ferr, w_brk}, 0);
        chk("post_reset_busy",  {29'd0, w_busy}, 0);

        // 8N1 basic frame with a latency check.
        send_frame(0, 9'h0A5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        wait_cyc(2 * c_CPB);

        // 7E1: 0x55 has four ones, so a parity bit of 0 is correct and 1 is an error.
        send_frame(1, 9'h055, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        wait_cyc(c_CPB);
        send_frame(1, 9'h055, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        wait_cyc(c_CPB);

        // 8N2 with the second stop bit low, then the line kept low.
        send_frame(2, 9'h042, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        wait_cyc(3 * 11 * c_CPB);
        chk("c_wait_high_busy", {31'd0, w_busy[2]}, 1);
        chk("c_frame_err_held", {31'd0, w_ferr[2]}, 1);
        r_line[2] = 1'b1;
        wait_cyc(2 * c_CPB);
        chk("c_idle_after_release", {31'd0, w_busy[2]}, 0);

        // Break: the 8N1 line is held low for three frame times.
        begin
            exp_t e;
            e.inst = 0; e.data = 9'h000; e.perr = 1'b0; e.ferr = 1'b1; e.brk = 1'b1;
            e.cyc  = cyc + c_SYNC + 1 + c_H + 1 + 9 * c_CPB;
            q_exp.push_back(e);
        end
        r_line[0] = 1'b0;
        wait_cyc(3 * 10 * c_CPB);
        chk("a_break_wait_busy", {31'd0, w_busy[0]}, 1);
        chk("a_break_held",      {31'd0, w_brk[0]}, 1);
        r_line[0] = 1'b1;
        wait_cyc(2 * c_CPB);
        chk("a_break_released_busy", {31'd0, w_busy[0]}, 0);
        send_frame(0, 9'h03C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        wait_cyc(2 * c_CPB);

        // One-cycle glitch while idle: START is entered, then abandoned by H+2 after T0.
        r_line[0] = 1'b0;
        wait_cyc(1);
        r_line[0] = 1'b1;
        wait_cyc(4);
        chk("glitch_start_busy", {31'd0, w_busy[0]}, 1);
        wait_cyc(c_H);
        chk("glitch_rejected_busy", {31'd0, w_busy[0]}, 0);
        chk("glitch_flags_kept", {29'd0, w_perr[0], w_ferr[0], w_brk[0]}, 0);
        wait_cyc(2 * c_CPB);

        // One-cycle glitches at mid-bit inside data bits 1 (a 0) and 2 (a 1).
        send_frame(0, 9'h0A5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        wait_cyc(c_CPB);
        send_frame(0, 9'h0A5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2);
        wait_cyc(c_CPB);

        // Back-to-back frames with no idle gap.
        send_frame(0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        send_frame(0, 9'h0FF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        send_frame(0, 9'h081, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        wait_cyc(2 * c_CPB);

        // Reset mid-frame: no pulse for the aborted frame, and outputs clear at once.
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        r_rst_n = 1'b0;
        #1;
        chk("midreset_byte_a", {23'd0, w_byte[0]}, 0);
        chk("midreset_busy",   {29'd0, w_busy}, 0);
        chk("midreset_perr_b", {31'd0, w_perr[1]}, 0);
        r_line[0] = 1'b1;
        wait_cyc(4);
        r_rst_n = 1'b1;
        wait_cyc(2 * c_CPB);
        chk("after_reset_idle", {31'd0, w_busy[0]}, 0);
        send_frame(0, 9'h096, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        wait_cyc(3 * c_CPB);

        chk("queue_drained", q_exp.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver that replaces the fixed 8N1 receiver in the serial front end. Data width, parity mode and stop-bit count are compile-time parameters. It adds an input synchroniser, 3-sample majority voting at mid-bit, and parity, framing and break detection. It sits between the board RX pin and the command/packet layer and delivers one word per frame, marked by a single-cycle valid pulse.

## Interface
- CLKS_PER_BIT, 217, clock cycles per bit (clock frequency / baud rate); legal range ≥ 8
- DATA_BITS, 8, data bits per frame; legal range 5–9
- PARITY_EN, 0, 1 means a parity bit follows the data
- PARITY_ODD, 0, 1 selects odd parity, 0 selects even; ignored when PARITY_EN = 0
- STOP_BITS, 1, number of stop bits; legal values 1 or 2
- SYNC_STAGES, 2, flip-flop stages on rx_serial_i; minimum 2
- clk_i  in  1  single system clock; all logic on its rising edge
- rst_ni  in  1  reset, asynchronous assert, active-low
- rx_serial_i  in  1  asynchronous serial line; idle level is high
- rx_dv_o  out  1  one-cycle pulse; word and error flags are valid in this cycle
- rx_byte_o  out  DATA_BITS  received word, LSB first on the wire
- parity_err_o  out  1  parity mismatch on the last frame
- frame_err_o  out  1  a stop bit sampled low on the last frame
- break_o  out  1  last frame was all-zero data, zero parity (if enabled) and a zero stop bit
- busy_o  out  1  high in every state except IDLE

## Operation
- Synchroniser:
  - SYNC_STAGES flops with reset value 1.
  - rxs denotes the synchronised line; all logic below uses rxs only.
- Bit counter:
  - Width $clog2(CLKS_PER_BIT).
  - Let H = CLKS_PER_BIT/2, using integer division.
- Majority voting:
  - rxs is sampled at counter values H-1, H and H+1.
  - The bit value is the 2-of-3 majority, decided at count H+1.
  - After a decision the counter runs to CLKS_PER_BIT-1, wraps to 0, and the next decision follows exactly CLKS_PER_BIT cycles later.
- States:
  - IDLE: counter = 0, bit index = 0. rxs = 0 → START.
  - START: at the decision point, vote 0 → DATA; vote 1 → IDLE (false start, no pulse, no flags changed).
  - DATA: the vote is shifted into bit[index]. After bit DATA_BITS-1 → PARITY if PARITY_EN, else STOP.
  - PARITY: the vote is stored. parity_bad = (XOR of data bits XOR vote) ≠ PARITY_ODD. → STOP.
  - STOP: one vote per stop bit. At the last stop vote, in the same cycle:
    - Load rx_byte_o and the three flags, and pulse rx_dv_o.
    - If every stop vote was 1 → IDLE; otherwise → WAIT_HIGH.
  - WAIT_HIGH: stays here until rxs = 1, then → IDLE. This prevents a break or stuck-low line from re-triggering.
- Flag rules:
  - frame_err_o = any stop vote was 0.
  - break_o = frame_err_o AND all data votes 0 AND (parity vote 0 OR PARITY_EN = 0).
  - parity_err_o = 0 when PARITY_EN = 0.
- Output holding: rx_byte_o and the flags hold until the next rx_dv_o. The word is delivered even when it has errors.
- Unused encodings → IDLE.

## Timing
- Reset values:
  - All outputs 0, rx_byte_o = 0, state IDLE.
  - Synchroniser flops are set to 1.
- Reset mid-frame: the frame is aborted with no rx_dv_o, and receive resumes from IDLE after reset release.
- Latency:
  - Let T0 be the edge at which rxs is first seen low in IDLE. Let N = DATA_BITS + PARITY_EN + STOP_BITS.
  - rx_dv_o is high in the cycle after edge T0 + H + 1 + N·CLKS_PER_BIT.
  - The pin-to-rxs delay of SYNC_STAGES cycles adds to this.
- rx_dv_o is exactly one cycle wide and never fires on consecutive cycles.
- The receiver re-arms half a bit early: IDLE is reached about H cycles before the end of the last stop bit, so a back-to-back start edge is caught with no frame lost.
- A start glitch of 1 cycle, or any glitch shorter than 2 of the 3 vote samples, is rejected.
- Bit-rate tolerance: sampling error stays within ±H−2 cycles over a frame.

## Test plan
- 8N1, CLKS_PER_BIT=16; send 0xA5 → one rx_dv_o pulse, rx_byte_o=0xA5, all flags 0, and pulse cycle matches the latency formula.
- DATA_BITS=7, PARITY_EN=1, PARITY_ODD=0:
  - Send 0x55 with parity bit 0 → parity_err_o=0.
  - Same data with parity bit 1 → parity_err_o=1, rx_byte_o=0x55.
- STOP_BITS=2; second stop bit driven low → frame_err_o=1, break_o=0. Line held low afterwards → no new pulse until the line returns high.
- Line held low for 3 frame times → a single pulse with rx_byte_o=0, frame_err_o=1, break_o=1, then the block stays in WAIT_HIGH. After release, the next 0x3C frame is received cleanly.
- 1-cycle low glitch in IDLE → no pulse, busy_o returns to 0 within H+2 cycles. 1-cycle glitch mid-data-bit → bit value unchanged.
- Back-to-back frames 0x00, 0xFF, 0x81 with no idle gap → three pulses with correct values. rst_ni asserted mid-frame → outputs 0 immediately, and no pulse for the aborted frame.
